// File: rtl/fp_rounding.sv
// fp_rounding: fifth stage of the floating-point adder.
// It rounds the normalized mantissa using the guard/round/sticky bits and
// handles the carry out of rounding, the promotion of a subnormal to the
// minimum normal, exponent overflow, infinity and NaN before packing.
// The stage is a two-register pipeline (S1 = captured operands,
// S2 = packed result) with a valid/ready handshake and full backpressure.

`ifndef FP16
`define FP16 16
`endif
`ifndef FP32
`define FP32 32
`endif
`ifndef FP64
`define FP64 64
`endif
`ifndef GET_EXP_LEN
`define GET_EXP_LEN(f) (((f) == `FP64) ? 11 : ((f) == `FP16) ? 5 : 8)
`endif
`ifndef GET_MANTISSA_LEN
`define GET_MANTISSA_LEN(f) (((f) == `FP64) ? 52 : ((f) == `FP16) ? 10 : 23)
`endif
`ifndef GET_PROTECT_LEN
`define GET_PROTECT_LEN(f) 3
`endif

module fp_rounding #(
    parameter int data_format = `FP32
) (
    input  logic                                                                 clk,
    input  logic                                                                 rst_n,
    input  logic                                                                 in_valid,
    output logic                                                                 in_ready,
    input  logic                                                                 in_sign,
    input  logic [`GET_EXP_LEN(data_format)-1:0]                                 in_exp,
    input  logic [`GET_MANTISSA_LEN(data_format)+`GET_PROTECT_LEN(data_format):0] in_mant,
    input  logic                                                                 in_nan,
    input  logic [1:0]                                                           rnd_mode,
    output logic                                                                 out_valid,
    input  logic                                                                 out_ready,
    output logic [`GET_EXP_LEN(data_format)+`GET_MANTISSA_LEN(data_format):0]    out_result,
    output logic                                                                 out_inexact,
    output logic                                                                 out_overflow
);

    localparam int E = `GET_EXP_LEN(data_format);
    localparam int M = `GET_MANTISSA_LEN(data_format);
    localparam int P = `GET_PROTECT_LEN(data_format);
    localparam int W = 1 + E + M;

    localparam logic [E:0] EXP_LIMIT = {1'b0, {E{1'b1}}};

    typedef enum logic [1:0] {
        RND_RNE = 2'd0,
        RND_RTZ = 2'd1,
        RND_RUP = 2'd2,
        RND_RDN = 2'd3
    } rnd_mode_t;

    // S1 operand register
    logic              s1_full;
    logic              s1_sign;
    logic [E-1:0]      s1_exp;
    logic [M+P:0]      s1_mant;
    logic              s1_nan;
    rnd_mode_t         s1_mode;

    // S2 result register
    logic              s2_full;
    logic [W-1:0]      s2_result;
    logic              s2_inexact;
    logic              s2_overflow;

    logic              s1_load;
    logic              s2_load;

    // rounding datapath
    logic [M:0]        kept;
    logic              g;
    logic              st;
    logic              inc;
    logic [M+1:0]      sum;
    logic [E:0]        exp_r;
    logic [M-1:0]      frac;
    logic              ovf;
    logic              to_inf;
    logic [W-1:0]      r_result;
    logic              r_inexact;
    logic              r_overflow;

    assign s2_load      = s1_full && (!s2_full || out_ready);
    assign s1_load      = in_valid && (!s1_full || s2_load);
    assign in_ready     = !s1_full || s2_load;

    assign out_valid    = s2_full;
    assign out_result   = s2_result;
    assign out_inexact  = s2_inexact;
    assign out_overflow = s2_overflow;

    // Capture an accepted beat into S1; S1 empties when it hands over to S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_full <= 1'b0;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_mant <= '0;
            s1_nan  <= 1'b0;
            s1_mode <= RND_RNE;
        end else begin
            if (s1_load) begin
                s1_full <= 1'b1;
                s1_sign <= in_sign;
                s1_exp  <= in_exp;
                s1_mant <= in_mant;
                s1_nan  <= in_nan;
                s1_mode <= rnd_mode_t'(rnd_mode);
            end else if (s2_load) begin
                s1_full <= 1'b0;
            end
        end
    end

    // Round, classify and pack the S1 operands.
    always_comb begin
        kept = s1_mant[M+P:P];
        g    = s1_mant[P-1];
        st   = |s1_mant[P-2:0];

        unique case (s1_mode)
            RND_RNE: inc = g & (st | kept[0]);
            RND_RTZ: inc = 1'b0;
            RND_RUP: inc = ~s1_sign & (g | st);
            RND_RDN: inc = s1_sign & (g | st);
            default: inc = 1'b0;
        endcase

        sum = {1'b0, kept} + {{(M+1){1'b0}}, inc};

        if (sum[M+1]) begin
            frac  = '0;
            exp_r = {1'b0, s1_exp} + (E+1)'(1);
        end else begin
            frac  = sum[M-1:0];
            exp_r = {1'b0, s1_exp} + (E+1)'((s1_exp == '0) && sum[M]);
        end

        // a mantissa that rounds to nothing is a signed zero
        if (sum == '0) begin
            exp_r = '0;
        end

        ovf    = (exp_r >= EXP_LIMIT);
        to_inf = (s1_mode == RND_RNE) ||
                 ((s1_mode == RND_RUP) && !s1_sign) ||
                 ((s1_mode == RND_RDN) && s1_sign);

        r_result   = {s1_sign, exp_r[E-1:0], frac};
        r_inexact  = g | st;
        r_overflow = 1'b0;

        if (s1_nan) begin
            r_result  = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
            r_inexact = 1'b0;
        end else if (s1_exp == '1) begin
            r_result  = {s1_sign, {E{1'b1}}, {M{1'b0}}};
            r_inexact = 1'b0;
        end else if (ovf) begin
            r_overflow = 1'b1;
            r_inexact  = 1'b1;
            if (to_inf) begin
                r_result = {s1_sign, {E{1'b1}}, {M{1'b0}}};
            end else begin
                r_result = {s1_sign, {(E-1){1'b1}}, 1'b0, {M{1'b1}}};
            end
        end
    end

    // S2 holds the packed result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_full     <= 1'b0;
            s2_result   <= '0;
            s2_inexact  <= 1'b0;
            s2_overflow <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_full     <= 1'b1;
                s2_result   <= r_result;
                s2_inexact  <= r_inexact;
                s2_overflow <= r_overflow;
            end else if (out_ready) begin
                s2_full     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_rounding.sv
// tb_fp_rounding: directed stimulus for the FP32 rounding stage with a
// scoreboard of expected results popped as results leave the stage.

module tb_fp_rounding;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [26:0] in_mant;
    logic        in_nan;
    logic [1:0]  rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_inexact;
    logic        out_overflow;

    typedef struct packed {
        logic [31:0] res;
        logic        inx;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;

    fp_rounding #(.data_format(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mant      (in_mant),
        .in_nan       (in_nan),
        .rnd_mode     (rnd_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_inexact  (out_inexact),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pop and compare whenever a result is handed to the consumer.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            check("output_expected", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("result",   64'(out_result),   64'(e.res));
                check("inexact",  64'(out_inexact),  64'(e.inx));
                check("overflow", 64'(out_overflow), 64'(e.ovf));
                pop_cyc.push_back(cycle);
            end
        end
    end

    task automatic drive(input logic s, input logic [7:0] e, input logic [26:0] m,
                         input logic n, input logic [1:0] md);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_nan   = n;
        rnd_mode = md;
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [26:0] m,
                        input logic n, input logic [1:0] md,
                        input logic [31:0] xr, input logic xi, input logic xo);
        bit acc = 1'b0;
        drive(s, e, m, n, md);
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) sb.push_back('{xr, xi, xo});
        check("accept_in_time", 64'(acc), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_nan    = 1'b0;
        rnd_mode  = 2'd0;
        out_ready = 1'b1;

        #1;
        check("rst_out_valid",    64'(out_valid),    64'd0);
        check("rst_out_result",   64'(out_result),   64'd0);
        check("rst_out_inexact",  64'(out_inexact),  64'd0);
        check("rst_out_overflow", 64'(out_overflow), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // RNE tie to even, with two-cycle latency
        send(0, 8'h7F, {1'b1, 23'h000000, 3'b100}, 0, 2'd0, 32'h3F800000, 1, 0);
        check("lat_not_yet", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_out_valid", 64'(out_valid), 64'd1);

        // RNE tie odd rounds up; RTZ truncates
        send(0, 8'h7F, {1'b1, 23'h000001, 3'b100}, 0, 2'd0, 32'h3F800002, 1, 0);
        send(0, 8'h7F, {1'b1, 23'h000001, 3'b100}, 0, 2'd1, 32'h3F800001, 1, 0);
        // carry out of the mantissa
        send(0, 8'h7F, {1'b1, 23'h7FFFFF, 3'b110}, 0, 2'd0, 32'h40000000, 1, 0);
        // overflow variants
        send(0, 8'hFE, {1'b1, 23'h7FFFFF, 3'b100}, 0, 2'd0, 32'h7F800000, 1, 1);
        send(0, 8'hFE, {1'b1, 23'h7FFFFF, 3'b100}, 0, 2'd1, 32'h7F7FFFFF, 1, 0);
        send(1, 8'hFE, {1'b1, 23'h7FFFFF, 3'b100}, 0, 2'd2, 32'hFF7FFFFF, 1, 0);
        send(0, 8'hFE, {1'b1, 23'h7FFFFF, 3'b100}, 0, 2'd2, 32'h7F800000, 1, 1);
        send(1, 8'hFE, {1'b1, 23'h7FFFFF, 3'b100}, 0, 2'd3, 32'hFF800000, 1, 1);
        send(1, 8'hFE, {1'b1, 23'h7FFFFF, 3'b100}, 0, 2'd0, 32'hFF800000, 1, 1);
        send(0, 8'hFE, {1'b1, 23'h7FFFFF, 3'b100}, 0, 2'd3, 32'h7F7FFFFF, 1, 0);
        // subnormal promotion and NaN
        send(0, 8'h00, {1'b0, 23'h7FFFFF, 3'b111}, 0, 2'd0, 32'h00800000, 1, 0);
        send(1, 8'h00, {1'b0, 23'h7FFFFF, 3'b111}, 1, 2'd0, 32'h7FC00000, 0, 0);
        // directed rounding on sticky only
        send(0, 8'h7F, {1'b1, 23'h000000, 3'b001}, 0, 2'd2, 32'h3F800001, 1, 0);
        send(0, 8'h7F, {1'b1, 23'h000000, 3'b001}, 0, 2'd3, 32'h3F800000, 1, 0);
        send(1, 8'h7F, {1'b1, 23'h000000, 3'b001}, 0, 2'd3, 32'hBF800001, 1, 0);
        // signed zero and infinity pass-through
        send(1, 8'h00, 27'h0, 0, 2'd2, 32'h80000000, 0, 0);
        send(0, 8'hFF, {1'b1, 23'h000000, 3'b000}, 0, 2'd0, 32'h7F800000, 0, 0);

        repeat (4) @(posedge clk);
        #1;
        check("drained_directed", 64'(sb.size()), 64'd0);

        // backpressure: two beats fill the pipe, the third stalls
        out_ready = 1'b0;
        send(0, 8'h7F, {1'b1, 23'h000001, 3'b100}, 0, 2'd1, 32'h3F800001, 1, 0);
        send(0, 8'h7F, {1'b1, 23'h000001, 3'b100}, 0, 2'd0, 32'h3F800002, 1, 0);
        drive(1, 8'h00, 27'h0, 0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(in_ready),   64'd0);
            check("bp_out_valid",    64'(out_valid),  64'd1);
            check("bp_out_hold",     64'(out_result), 64'h3F800001);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(1, 8'h00, 27'h0, 0, 2'd0, 32'h80000000, 0, 0);
        send(0, 8'hFF, {1'b1, 23'h000000, 3'b000}, 0, 2'd0, 32'h7F800000, 0, 0);
        send(1, 8'h7F, {1'b1, 23'h000000, 3'b001}, 0, 2'd3, 32'hBF800001, 1, 0);
        repeat (4) @(posedge clk);
        #1;
        check("drained_bp", 64'(sb.size()), 64'd0);
        n = pop_cyc.size();
        for (int i = 0; i < 4; i++) begin
            check("bp_one_per_cycle", 64'(pop_cyc[n-4+i] - pop_cyc[n-5+i]), 64'd1);
        end

        // reset mid-stream drops the in-flight beats
        send(0, 8'h7F, {1'b1, 23'h000001, 3'b100}, 0, 2'd0, 32'h3F800002, 1, 0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        drive(0, 8'h7F, {1'b1, 23'h000003, 3'b000}, 0, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", 64'(out_valid), 64'd0);
        sb.delete();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale_beat", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(0, 8'h80, {1'b1, 23'h000002, 3'b011}, 0, 2'd0, 32'h40000002, 1, 0);
        repeat (4) @(posedge clk);
        #1;
        check("drained_final", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
